// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline encodings: writeback select, load funct3, opcodes.
package rv32_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned CNT_W    = 64;

    typedef enum logic [1:0] {
        WB_MEM  = 2'b00,
        WB_ALU  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/load_align.sv
// Load data extraction and sign/zero extension from an aligned memory word.
module load_align
    import rv32_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed byte/half, then extend by width and signedness
    always_comb begin
        data   = '0;
        err    = 1'b0;
        byte_v = mem_rdata[8*off +: 8];
        half_v = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            F3_LB:  data = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data = {24'h0, byte_v};
            F3_LH: begin
                data = {{16{half_v[15]}}, half_v};
                err  = off[0];
            end
            F3_LHU: begin
                data = {16'h0, half_v};
                err  = off[0];
            end
            F3_LW: begin
                data = mem_rdata;
                err  = (off != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: writeback select, RF write port, retire counter, sticky error.
module wb_stage
    import rv32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [1:0]        wb_sel,
    input  logic              reg_we,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [XLEN-1:0]   pc,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retire_count,
    output logic              wb_err
);

    logic [XLEN-1:0]   load_data;
    logic              load_err;
    logic [XLEN-1:0]   wdata_c;
    logic              err_c;

    logic              rf_we_q,    rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [CNT_W-1:0]  retire_count_q, retire_count_d;
    logic              wb_err_q,   wb_err_d;

    load_align u_load_align (
        .funct3    (funct3),
        .off       (alu_result[1:0]),
        .mem_rdata (mem_rdata),
        .data      (load_data),
        .err       (load_err)
    );

    // Writeback source mux and error decode for the entry presented this cycle
    always_comb begin
        wdata_c = '0;
        err_c   = 1'b0;
        case (wb_sel)
            WB_MEM: begin
                wdata_c = load_data;
                err_c   = load_err;
            end
            WB_ALU:  wdata_c = alu_result;
            WB_PC4:  wdata_c = pc + XLEN'(4);
            default: err_c   = 1'b1;
        endcase
    end

    // Next-state: flush makes a bubble; error entries are captured as not valid
    always_comb begin
        rf_waddr_d     = rd_addr;
        rf_wdata_d     = wdata_c;
        wb_valid_d     = 1'b0;
        rf_we_d        = 1'b0;
        wb_err_d       = wb_err_q;
        retire_count_d = retire_count_q + CNT_W'(wb_valid_q);
        if (!flush) begin
            wb_valid_d = in_valid & ~err_c;
            rf_we_d    = in_valid & reg_we & (rd_addr != '0) & ~err_c;
            wb_err_d   = wb_err_q | (in_valid & err_c);
        end
    end

    // Pipeline register and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            wb_valid_q     <= 1'b0;
            retire_count_q <= '0;
            wb_err_q       <= 1'b0;
        end else begin
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            wb_valid_q     <= wb_valid_d;
            retire_count_q <= retire_count_d;
            wb_err_q       <= wb_err_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign retire_count = retire_count_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with an expected-result queue.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, reg_we;
    logic [1:0]  wb_sel;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic [31:0] alu_result, mem_rdata, pc;
    logic        rf_we, wb_valid, wb_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] retire_count;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_count = '0;
    logic        exp_err   = 1'b0;
    logic        prev_valid = 1'b0;

    wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .flush        (flush),
        .wb_sel       (wb_sel),
        .reg_we       (reg_we),
        .rd_addr      (rd_addr),
        .funct3       (funct3),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .pc           (pc),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .wb_valid     (wb_valid),
        .retire_count (retire_count),
        .wb_err       (wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One entry: drive at negedge, push expectation, compare after the capture edge
    task automatic step(input string tag, input logic v, input logic fl, input logic [1:0] sel,
                        input logic we, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pcv,
                        input logic is_err, input logic exp_we, input logic [31:0] exp_data);
        exp_t e;
        @(negedge clk);
        in_valid = v; flush = fl; wb_sel = sel; reg_we = we; rd_addr = rd;
        funct3 = f3; alu_result = alu; mem_rdata = rdata; pc = pcv;
        e.valid    = v & ~fl & ~is_err;
        e.we       = exp_we;
        e.waddr    = rd;
        e.wdata    = exp_data;
        e.chk_data = e.valid | exp_we;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        exp_count = exp_count + 64'(prev_valid);
        exp_err   = exp_err | (v & ~fl & is_err);
        prev_valid = e.valid;
        chk({tag, ".valid"}, 64'(wb_valid), 64'(e.valid));
        chk({tag, ".we"},    64'(rf_we),    64'(e.we));
        if (e.chk_data) begin
            chk({tag, ".waddr"}, 64'(rf_waddr), 64'(e.waddr));
            chk({tag, ".wdata"}, 64'(rf_wdata), 64'(e.wdata));
        end
        chk({tag, ".cnt"}, retire_count, exp_count);
        chk({tag, ".err"}, 64'(wb_err), 64'(exp_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step("idle", 1'b0, 1'b0, 2'b01, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_sel = 2'b00; reg_we = 1'b0;
        rd_addr = '0; funct3 = '0; alu_result = '0; mem_rdata = '0; pc = '0;
        #12;
        chk("rst.we",    64'(rf_we),    64'd0);
        chk("rst.waddr", 64'(rf_waddr), 64'd0);
        chk("rst.wdata", 64'(rf_wdata), 64'd0);
        chk("rst.valid", 64'(wb_valid), 64'd0);
        chk("rst.cnt",   retire_count,  64'd0);
        chk("rst.err",   64'(wb_err),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Per-source writes
        step("alu", 1, 0, 2'b01, 1, 5'd5, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 1, 32'h1234_5678);
        step("pc4", 1, 0, 2'b10, 1, 5'd7, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 1, 32'h0);

        // Load formatting
        step("lb3",  1, 0, 2'b00, 1, 5'd1, 3'b000, 32'h1003, RD, 32'h0, 0, 1, 32'hFFFF_FF80);
        step("lbu3", 1, 0, 2'b00, 1, 5'd2, 3'b100, 32'h1003, RD, 32'h0, 0, 1, 32'h0000_0080);
        step("lh2",  1, 0, 2'b00, 1, 5'd3, 3'b001, 32'h1002, RD, 32'h0, 0, 1, 32'hFFFF_80FF);
        step("lhu0", 1, 0, 2'b00, 1, 5'd4, 3'b101, 32'h1000, RD, 32'h0, 0, 1, 32'h0000_7F01);
        step("lw",   1, 0, 2'b00, 1, 5'd6, 3'b010, 32'h1000, RD, 32'h0, 0, 1, 32'h80FF_7F01);
        step("lb1",  1, 0, 2'b00, 1, 5'd8, 3'b000, 32'h1001, RD, 32'h0, 0, 1, 32'h0000_007F);
        step("lbu2", 1, 0, 2'b00, 1, 5'd9, 3'b100, 32'h1002, RD, 32'h0, 0, 1, 32'h0000_00FF);
        step("lh0",  1, 0, 2'b00, 1, 5'd10, 3'b001, 32'h1000, RD, 32'h0, 0, 1, 32'h0000_7F01);
        step("lhu2", 1, 0, 2'b00, 1, 5'd11, 3'b101, 32'h1002, RD, 32'h0, 0, 1, 32'h0000_80FF);
        step("noreg", 1, 0, 2'b01, 0, 5'd12, 3'd0, 32'hAAAA_5555, 32'h0, 32'h0, 0, 0, 32'hAAAA_5555);

        // x0 retires without writing; flush wins over in_valid
        step("x0",    1, 0, 2'b01, 1, 5'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF);
        step("flush", 1, 1, 2'b01, 1, 5'd13, 3'd0, 32'h1111_1111, 32'h0, 32'h0, 0, 0, 32'h0);
        step("flerr", 1, 1, 2'b11, 1, 5'd13, 3'd0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        idle(2);

        // Error entries: no write, no count, sticky flag
        step("lwmis", 1, 0, 2'b00, 1, 5'd14, 3'b010, 32'h1002, RD, 32'h0, 1, 0, 32'h0);
        idle(10);
        step("rsvd",  1, 0, 2'b11, 1, 5'd15, 3'd0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        step("f3ill", 1, 0, 2'b00, 1, 5'd16, 3'b011, 32'h1000, RD, 32'h0, 1, 0, 32'h0);
        step("lhmis", 1, 0, 2'b00, 1, 5'd17, 3'b001, 32'h1001, RD, 32'h0, 1, 0, 32'h0);
        idle(10);

        // Reset mid-stream with a valid entry in the WB register
        step("prerst", 1, 0, 2'b01, 1, 5'd18, 3'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 1, 32'hCAFE_F00D);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.we",    64'(rf_we),    64'd0);
        chk("mrst.valid", 64'(wb_valid), 64'd0);
        chk("mrst.cnt",   retire_count,  64'd0);
        chk("mrst.err",   64'(wb_err),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_count = '0; exp_err = 1'b0; prev_valid = 1'b0;
        idle(2);

        // 100 back-to-back entries
        for (int i = 0; i < 100; i++)
            step("b2b", 1, 0, 2'b01, 1, 5'((i % 31) + 1), 3'd0, 32'(i * 3 + 1), 32'h0, 32'h0,
                 0, 1, 32'(i * 3 + 1));
        idle(2);
        chk("cnt100", retire_count, 64'd100);

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.retire_count_q = '1;
        exp_count = '1;
        prev_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        release dut.retire_count_q;
        step("wrap", 1, 0, 2'b01, 1, 5'd20, 3'd0, 32'h0000_0042, 32'h0, 32'h0, 0, 1, 32'h0000_0042);
        idle(1);
        chk("wrap0", retire_count, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
